// File: rtl/db_pkg.sv
// Shared definitions for the db_cont request feeder: op/state encodings,
// default widths and the flow hash used at FIFO write time.
package db_pkg;

  localparam int unsigned DB_KEY_SIZE  = 96;
  localparam int unsigned DB_VAL_SIZE  = 32;
  localparam int unsigned DB_HASH_SIZE = 32;
  localparam int unsigned DB_OP_SIZE   = 4;

  // Widest key the hash folds; narrower keys are zero-padded up to this.
  localparam int unsigned DB_KEY_MAX   = 256;

  // req_op bit0
  localparam logic SET_REQ = 1'b1;
  localparam logic GET_REQ = 1'b0;

  // Requested flow state carried in req_op[2:1]
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SUSPECT = 2'b01,
    ARREST  = 2'b10,
    EXPIRE  = 2'b11
  } flow_state_t;

  // Fold every 32-bit key word together, then mix with a half-word rotate
  // and a right shift. Zero padding words do not disturb the XOR fold.
  function automatic logic [31:0] flow_hash(input logic [DB_KEY_MAX-1:0] key);
    logic [31:0] h0;
    h0 = '0;
    for (int unsigned i = 0; i < DB_KEY_MAX / 32; i++) begin
      h0 ^= key[i*32 +: 32];
    end
    return h0 ^ {h0[15:0], h0[31:16]} ^ (h0 >> 7);
  endfunction

endpackage

// File: rtl/db_req_fifo.sv
// Synchronous request FIFO with wrap-bit pointers; head entry is visible
// combinationally on rdata whenever the FIFO is not empty.
module db_req_fifo
  import db_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards contents by collapsing both pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; entries need no reset since empty/full come from pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/db_req_gen.sv
// Upstream feeder for db_cont: accepts parsed flow requests, hashes the key,
// queues them and issues one request per ISSUE_GAP cycles, holding the
// issued fields stable for db_cont's lookup/update window.
module db_req_gen
  import db_pkg::*;
#(
  parameter int unsigned KEY_SIZE   = DB_KEY_SIZE,
  parameter int unsigned VAL_SIZE   = DB_VAL_SIZE,
  parameter int unsigned HASH_SIZE  = DB_HASH_SIZE,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ISSUE_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [KEY_SIZE-1:0]   req_key,
  input  logic [VAL_SIZE-1:0]   req_value,
  output logic                  db_valid,
  output logic [3:0]            db_op,
  output logic [HASH_SIZE-1:0]  db_hash,
  output logic [KEY_SIZE-1:0]   db_key,
  output logic [VAL_SIZE-1:0]   db_value,
  output logic [31:0]           issued_cnt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = $clog2(ISSUE_GAP) + 1;

  typedef struct packed {
    logic [3:0]           op;
    logic [HASH_SIZE-1:0] hash;
    logic [KEY_SIZE-1:0]  key;
    logic [VAL_SIZE-1:0]  value;
  } req_entry_t;

  typedef enum logic {
    ISS_IDLE = 1'b0,
    ISS_HOLD = 1'b1
  } issue_state_t;

  req_entry_t    wr_entry;
  req_entry_t    rd_entry;
  logic          push;
  logic          issue;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] unused_fifo_count;

  issue_state_t  state_q;
  issue_state_t  state_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [31:0]   issued_q;

  // Ready is held low throughout reset, otherwise only back-pressure from a full FIFO.
  assign req_ready = rst && !fifo_full;
  assign push      = req_valid && req_ready;

  assign wr_entry.op    = req_op;
  assign wr_entry.hash  = HASH_SIZE'(flow_hash(DB_KEY_MAX'(req_key)));
  assign wr_entry.key   = req_key;
  assign wr_entry.value = req_value;

  db_req_fifo #(
    .WIDTH ($bits(req_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // Issue FSM state and gap counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ISS_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state: issue from IDLE, then count down the gap in HOLD.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      ISS_IDLE: begin
        if (!fifo_empty && (gap_q == '0)) begin
          issue   = 1'b1;
          gap_d   = GW'(ISSUE_GAP - 1);
          state_d = ISS_HOLD;
        end
      end
      ISS_HOLD: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = ISS_IDLE;
      end
      default: begin
        state_d = ISS_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Issue registers: one-cycle strobe, fields held until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_valid <= 1'b0;
      db_op    <= '0;
      db_hash  <= '0;
      db_key   <= '0;
      db_value <= '0;
      issued_q <= '0;
    end else begin
      db_valid <= issue;
      if (issue) begin
        db_op    <= rd_entry.op;
        db_hash  <= rd_entry.hash;
        db_key   <= rd_entry.key;
        db_value <= rd_entry.value;
        issued_q <= issued_q + 32'd1;
      end
    end
  end

  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_db_req_gen.sv
// Directed self-checking bench for db_req_gen.
module tb_db_req_gen;
  import db_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [95:0] req_key = '0;
  logic [31:0] req_value = '0;
  logic        db_valid;
  logic [3:0]  db_op;
  logic [31:0] db_hash;
  logic [95:0] db_key;
  logic [31:0] db_value;
  logic [31:0] issued_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  logic [95:0] st_key [16];
  logic [31:0] st_val [16];
  logic [3:0]  st_op  [16];
  logic [95:0] ob_key [16];
  logic [31:0] ob_val [16];
  logic [3:0]  ob_op  [16];
  logic [31:0] ob_hash[16];
  int          ob_cyc [16];
  int          n_obs;
  bit          full_seen;
  int          acc_at_full;
  int          iss_at_full;

  always #5 clk = ~clk;

  db_req_gen #(
    .KEY_SIZE   (96),
    .VAL_SIZE   (32),
    .HASH_SIZE  (32),
    .FIFO_DEPTH (8),
    .ISSUE_GAP  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_key    (req_key),
    .req_value  (req_value),
    .db_valid   (db_valid),
    .db_op      (db_op),
    .db_hash    (db_hash),
    .db_key     (db_key),
    .db_value   (db_value),
    .issued_cnt (issued_cnt)
  );

  // Drives st_* entries 0..n-1 with req_valid held high, records every
  // db_valid pulse (cycle index counts edges from the first drive), then
  // idles 4 cycles so the issue FSM is back in IDLE. Called at #1 after an edge.
  task automatic stream(input int n, input int budget);
    int  pushed = 0;
    int  cyc = 0;
    bit  acc;
    n_obs = 0;
    full_seen = 0;
    acc_at_full = -1;
    iss_at_full = -1;
    while ((pushed < n || n_obs < n) && cyc < budget) begin
      if (pushed < n) begin
        req_valid = 1'b1;
        req_key   = st_key[pushed];
        req_value = st_val[pushed];
        req_op    = st_op[pushed];
      end else begin
        req_valid = 1'b0;
      end
      acc = req_valid && req_ready;
      if (!req_ready && !full_seen) begin
        full_seen   = 1;
        acc_at_full = pushed;
        iss_at_full = n_obs;
      end
      @(posedge clk); #1;
      if (acc) pushed++;
      if (db_valid) begin
        if (n_obs < 16) begin
          ob_key[n_obs]  = db_key;
          ob_val[n_obs]  = db_value;
          ob_op[n_obs]   = db_op;
          ob_hash[n_obs] = db_hash;
          ob_cyc[n_obs]  = cyc;
        end
        n_obs++;
      end
      cyc++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (db_valid) n_obs++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (db_valid !== 1'b0) begin n_fail++; $display("FAIL rst_db_valid: got %b want 0", db_valid); end
    n_cmp++; if ({db_op, db_hash, db_key, db_value} !== '0) begin n_fail++; $display("FAIL rst_db_fields: got %h want 0", {db_op, db_hash, db_key, db_value}); end
    n_cmp++; if (issued_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_issued_cnt: got %h want 0", issued_cnt); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready_in_reset: got %b want 0", req_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready_after: got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_get();
    logic [95:0] k;
    k = 96'h0A000001_0A000002_1F900050;
    st_key[0] = k; st_val[0] = 32'hDEAD_0001; st_op[0] = 4'h0;
    stream(1, 20);
    n_cmp++; if (n_obs !== 1) begin n_fail++; $display("FAIL t1_pulse_count: got %0d want 1", n_obs); end
    n_cmp++; if (ob_cyc[0] !== 1) begin n_fail++; $display("FAIL t1_latency: got cycle %0d want 1", ob_cyc[0]); end
    n_cmp++; if (ob_hash[0] !== 32'h1FFC3FC3) begin n_fail++; $display("FAIL t1_hash: got %h want 1ffc3fc3", ob_hash[0]); end
    n_cmp++; if (ob_key[0] !== k) begin n_fail++; $display("FAIL t1_key: got %h want %h", ob_key[0], k); end
    n_cmp++; if (ob_op[0] !== 4'h0) begin n_fail++; $display("FAIL t1_op: got %h want 0", ob_op[0]); end
    n_cmp++; if (issued_cnt !== 32'd1) begin n_fail++; $display("FAIL t1_issued_cnt: got %0d want 1", issued_cnt); end
    // Fields must still hold 4+ cycles after the strobe.
    n_cmp++; if (db_key !== k) begin n_fail++; $display("FAIL t1_key_held: got %h want %h", db_key, k); end
    n_cmp++; if (db_value !== 32'hDEAD_0001) begin n_fail++; $display("FAIL t1_value_held: got %h want dead0001", db_value); end
    n_cmp++; if (db_hash !== 32'h1FFC3FC3) begin n_fail++; $display("FAIL t1_hash_held: got %h want 1ffc3fc3", db_hash); end
    n_cmp++; if (db_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_low: got %b want 0", db_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      st_key[i] = {32'hC0A8_0000 + 32'(i), 32'h0A00_0001, 32'h0050_1F90};
      st_val[i] = 32'(i + 1);
      st_op[i]  = 4'h1;
    end
    stream(5, 60);
    n_cmp++; if (n_obs !== 5) begin n_fail++; $display("FAIL t2_pulse_count: got %0d want 5", n_obs); end
    n_cmp++; if (ob_cyc[0] !== 1) begin n_fail++; $display("FAIL t2_first_latency: got cycle %0d want 1", ob_cyc[0]); end
    for (int i = 0; i < 5 && i < n_obs; i++) begin
      n_cmp++; if (ob_val[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL t2_value[%0d]: got %0d want %0d", i, ob_val[i], i + 1); end
      n_cmp++; if (ob_op[i] !== 4'h1) begin n_fail++; $display("FAIL t2_op[%0d]: got %h want 1", i, ob_op[i]); end
      if (i > 0) begin
        n_cmp++; if (ob_cyc[i] - ob_cyc[i-1] !== 4) begin n_fail++; $display("FAIL t2_spacing[%0d]: got %0d want 4", i, ob_cyc[i] - ob_cyc[i-1]); end
      end
    end
    n_cmp++; if (issued_cnt !== 32'd6) begin n_fail++; $display("FAIL t2_issued_cnt: got %0d want 6", issued_cnt); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 12; i++) begin
      st_key[i] = {32'h0B00_0000 + 32'(i), 32'h0B00_00FF, 32'h1234_0000 + 32'(i)};
      st_val[i] = 32'd101 + 32'(i);
      st_op[i]  = (i % 2 == 0) ? 4'h1 : 4'h0;
    end
    stream(12, 120);
    n_cmp++; if (n_obs !== 12) begin n_fail++; $display("FAIL t3_pulse_count: got %0d want 12", n_obs); end
    n_cmp++; if (full_seen !== 1'b1) begin n_fail++; $display("FAIL t3_ready_dropped: got %b want 1", full_seen); end
    n_cmp++; if (acc_at_full !== 11) begin n_fail++; $display("FAIL t3_accepted_at_full: got %0d want 11", acc_at_full); end
    n_cmp++; if (acc_at_full - iss_at_full !== 8) begin n_fail++; $display("FAIL t3_level_at_full: got %0d want 8", acc_at_full - iss_at_full); end
    for (int i = 0; i < 12 && i < n_obs; i++) begin
      n_cmp++; if (ob_val[i] !== 32'd101 + 32'(i)) begin n_fail++; $display("FAIL t3_value[%0d]: got %0d want %0d", i, ob_val[i], 101 + i); end
      n_cmp++; if (ob_key[i] !== st_key[i]) begin n_fail++; $display("FAIL t3_key[%0d]: got %h want %h", i, ob_key[i], st_key[i]); end
    end
    n_cmp++; if (issued_cnt !== 32'd18) begin n_fail++; $display("FAIL t3_issued_cnt: got %0d want 18", issued_cnt); end
  endtask

  task automatic test_hash();
    st_key[0] = '0; st_val[0] = 32'h0000_00AA; st_op[0] = 4'h0;
    stream(1, 20);
    n_cmp++; if (n_obs !== 1) begin n_fail++; $display("FAIL t4_zero_pulse: got %0d want 1", n_obs); end
    n_cmp++; if (ob_hash[0] !== 32'h0) begin n_fail++; $display("FAIL t4_hash_zero: got %h want 00000000", ob_hash[0]); end
    st_key[0] = 96'h1; st_val[0] = 32'h0000_00BB; st_op[0] = 4'h3;
    stream(1, 20);
    n_cmp++; if (n_obs !== 1) begin n_fail++; $display("FAIL t4_one_pulse: got %0d want 1", n_obs); end
    n_cmp++; if (ob_hash[0] !== 32'h0001_0001) begin n_fail++; $display("FAIL t4_hash_one: got %h want 00010001", ob_hash[0]); end
    n_cmp++; if (ob_op[0] !== 4'h3) begin n_fail++; $display("FAIL t4_op: got %h want 3", ob_op[0]); end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_key   = {32'h0C00_0000 + 32'(i), 64'h0};
      req_value = 32'h0000_0C00 + 32'(i);
      req_op    = 4'h1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    // One entry issued, three queued, FSM mid-HOLD.
    n_cmp++; if (db_value !== 32'h0000_0C00) begin n_fail++; $display("FAIL t5_pre_value: got %h want 00000c00", db_value); end
    #3;
    rst = 1'b0;
    #1;
    n_cmp++; if (db_valid !== 1'b0) begin n_fail++; $display("FAIL t5_valid_async: got %b want 0", db_valid); end
    n_cmp++; if ({db_op, db_hash, db_key, db_value} !== '0) begin n_fail++; $display("FAIL t5_fields_async: got %h want 0", {db_op, db_hash, db_key, db_value}); end
    n_cmp++; if (issued_cnt !== 32'd0) begin n_fail++; $display("FAIL t5_cnt_async: got %0d want 0", issued_cnt); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL t5_ready_in_reset: got %b want 0", req_ready); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (db_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL t5_stale_issue: got %0d pulses want 0", pulses); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL t5_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_wrap();
    force dut.issued_q = 32'hFFFF_FFFF;
    #1;
    release dut.issued_q;
    n_cmp++; if (issued_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t6_preset: got %h want ffffffff", issued_cnt); end
    st_key[0] = 96'h5; st_val[0] = 32'h0000_0077; st_op[0] = 4'h1;
    stream(1, 20);
    n_cmp++; if (n_obs !== 1) begin n_fail++; $display("FAIL t6_pulse: got %0d want 1", n_obs); end
    n_cmp++; if (issued_cnt !== 32'd0) begin n_fail++; $display("FAIL t6_wrap: got %h want 00000000", issued_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_get();
    test_back_to_back();
    test_fill();
    test_hash();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
